// File: rtl/ram_byte_access_ctrl.sv
// Load/store engine for the 1536x8 data RAM: serialises 32-bit RISC-V loads and
// stores into little-endian byte accesses, with alignment and range rejection.
module ram_byte_access_ctrl #(
    parameter int RAM_AW    = 11,
    parameter int RAM_DEPTH = 1536
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WRITE,
    input  logic [1:0]        REQ_SIZE,
    input  logic              REQ_UNSIGNED,
    input  logic [31:0]       REQ_ADDR,
    input  logic [31:0]       REQ_WDATA,
    output logic              RESP_VALID,
    output logic              RESP_ERR,
    output logic [31:0]       RESP_RDATA,
    output logic              RAM_RE,
    output logic [RAM_AW-1:0] RAM_RADDR,
    input  logic [7:0]        RAM_RDATA,
    output logic              RAM_WE,
    output logic [RAM_AW-1:0] RAM_WADDR,
    output logic [7:0]        RAM_WDATA
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    localparam logic [31:0] DEPTH32 = 32'(RAM_DEPTH);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              wr_q, wr_d;
    logic              err_q, err_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       asm_q, asm_d;
    logic [RAM_AW-1:0] raddr_q, raddr_d;
    logic [RAM_AW-1:0] waddr_q, waddr_d;
    logic [7:0]        wbyte_q, wbyte_d;

    logic [2:0]  nb;
    logic        req_err;
    logic [1:0]  wsel, csel;
    logic [31:0] ext;

    assign nb   = 3'd1 << size_q;
    assign wsel = 2'(cnt_q + 3'd1);
    assign csel = 2'(cnt_q - 3'd1);

    always_comb begin
        req_err = (REQ_SIZE == 2'b11)
               || (REQ_SIZE == 2'b01 && REQ_ADDR[0])
               || (REQ_SIZE == 2'b10 && REQ_ADDR[1:0] != 2'b00)
               || (REQ_ADDR >= DEPTH32);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        uns_d   = uns_q;
        wr_d    = wr_q;
        err_d   = err_q;
        wdata_d = wdata_q;
        asm_d   = asm_q;
        raddr_d = raddr_q;
        waddr_d = waddr_q;
        wbyte_d = wbyte_q;
        case (state_q)
            IDLE: begin
                if (REQ_VALID) begin
                    size_d  = REQ_SIZE;
                    uns_d   = REQ_UNSIGNED;
                    wr_d    = REQ_WRITE;
                    wdata_d = REQ_WDATA;
                    err_d   = req_err;
                    cnt_d   = 3'd0;
                    asm_d   = 32'd0;
                    if (req_err) begin
                        state_d = RESP;
                    end else if (REQ_WRITE) begin
                        state_d = WRITE;
                        waddr_d = REQ_ADDR[RAM_AW-1:0];
                        wbyte_d = REQ_WDATA[7:0];
                    end else begin
                        state_d = READ;
                        raddr_d = REQ_ADDR[RAM_AW-1:0];
                    end
                end
            end
            WRITE: begin
                if (cnt_q == nb - 3'd1) begin
                    state_d = RESP;
                end else begin
                    cnt_d   = cnt_q + 3'd1;
                    waddr_d = waddr_q + 1'b1;
                    wbyte_d = wdata_q[{wsel, 3'b000} +: 8];
                end
            end
            READ: begin
                // RAM data lags the address by one cycle, hence the extra cycle
                // and the address parked on the last byte.
                if (cnt_q != 3'd0) asm_d[{csel, 3'b000} +: 8] = RAM_RDATA;
                if (cnt_q == nb) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q + 3'd1 < nb) raddr_d = raddr_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            asm_q   <= '0;
            raddr_q <= '0;
            waddr_q <= '0;
            wbyte_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            wdata_q <= wdata_d;
            asm_q   <= asm_d;
            raddr_q <= raddr_d;
            waddr_q <= waddr_d;
            wbyte_q <= wbyte_d;
        end
    end

    always_comb begin
        case (size_q)
            2'b00:   ext = {{24{~uns_q & asm_q[7]}}, asm_q[7:0]};
            2'b01:   ext = {{16{~uns_q & asm_q[15]}}, asm_q[15:0]};
            default: ext = asm_q;
        endcase
    end

    assign REQ_READY  = (state_q == IDLE);
    assign RAM_WE     = (state_q == WRITE);
    assign RAM_RE     = (state_q == READ);
    assign RESP_VALID = (state_q == RESP);
    assign RESP_ERR   = RESP_VALID & err_q;
    assign RESP_RDATA = (RESP_VALID && !err_q && !wr_q) ? ext : 32'd0;
    assign RAM_RADDR  = raddr_q;
    assign RAM_WADDR  = waddr_q;
    assign RAM_WDATA  = wbyte_q;

endmodule
